// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU control decoder and its mult/div unit.
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_MFHI = 3'b101;
    localparam logic [2:0] ALU_MFLO = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit
// per step. After WIDTH steps {acc, shreg} holds the product (mul), or
// acc = remainder and shreg = quotient (div).
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] shreg,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    // One-step arithmetic; the divide subtract fits WIDTH bits whenever rem_ge holds.
    always_comb begin
        mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : '0);
        rem_sh  = {acc, shreg[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opb});
        rem_sub = rem_sh[WIDTH-1:0] - opb;
    end

    // Operand load, per-step shift and iteration down-counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc   <= '0;
            shreg <= '0;
            opb   <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= '0;
            shreg <= op_a;
            opb   <= op_b;
            cnt   <= CW'(WIDTH - 1);
        end else if (step) begin
            if (!mode) begin
                acc   <= mul_sum[WIDTH:1];
                shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
            end else if (rem_ge) begin
                acc   <= rem_sub;
                shreg <= {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc   <= rem_sh[WIDTH-1:0];
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with an iterative mult/div unit and HI/LO.
//   state   | meaning
//   IDLE    | waiting for a mult/div start
//   MUL     | shift-add iterations
//   DIV     | restoring-divide iterations
//   DONE    | sign-correct result, commit HI/LO on exit, pulse done_o
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [2:0]       ALUCtrl_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e state, state_nx;

    logic             is_mul, is_div, op_signed, start, div_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, ld_a;
    logic             dp_load, dp_step, dp_last;
    logic [WIDTH-1:0] dp_acc, dp_sh;
    logic             neg_q, rneg_q, div_q, div0_pend_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] hi_res, lo_res;

    // Zero-latency ALU operation decode.
    always_comb begin
        ALUCtrl_o = ALU_NOP;
        if (ALUOp_i == ALUOP_MEM) begin
            ALUCtrl_o = ALU_ADD;
        end else begin
            case (funct_i)
                FN_ADD:  ALUCtrl_o = ALU_ADD;
                FN_SUB:  ALUCtrl_o = ALU_SUB;
                FN_AND:  ALUCtrl_o = ALU_AND;
                FN_OR:   ALUCtrl_o = ALU_OR;
                FN_MFHI: ALUCtrl_o = ALU_MFHI;
                FN_MFLO: ALUCtrl_o = ALU_MFLO;
                FN_SLT:  ALUCtrl_o = ALU_SLT;
                default: ALUCtrl_o = ALU_NOP;
            endcase
        end
    end

    // Start detection and operand magnitudes; a zero divisor passes the raw
    // dividend through so it lands in HI unchanged.
    always_comb begin
        is_mul    = (funct_i == FN_MULT) || (funct_i == FN_MULTU);
        is_div    = DIV_EN && ((funct_i == FN_DIV) || (funct_i == FN_DIVU));
        op_signed = (funct_i == FN_MULT) || (funct_i == FN_DIV);
        start     = (state == ST_IDLE) && valid_i && !flush_i &&
                    (ALUOp_i == ALUOP_RTYPE) && (is_mul || is_div);
        a_neg     = op_signed && src1_i[WIDTH-1];
        b_neg     = op_signed && src2_i[WIDTH-1];
        a_mag     = a_neg ? -src1_i : src1_i;
        b_mag     = b_neg ? -src2_i : src2_i;
        div_zero  = is_div && (src2_i == '0);
        ld_a      = div_zero ? src1_i : a_mag;
    end

    // Next-state, datapath control and handshake outputs.
    always_comb begin
        state_nx = state;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    dp_load  = 1'b1;
                    state_nx = div_zero ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush_i) begin
                    state_nx = ST_IDLE;
                end else begin
                    dp_step = 1'b1;
                    if (dp_last) state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        stall_o = start || (state == ST_MUL) || (state == ST_DIV);
        done_o  = (state == ST_DONE) && !flush_i;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nx;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load    (dp_load),
        .step    (dp_step),
        .mode    (state == ST_DIV),
        .op_a    (ld_a),
        .op_b    (b_mag),
        .acc     (dp_acc),
        .shreg   (dp_sh),
        .last    (dp_last)
    );

    // Sign correction of the unsigned magnitude result.
    always_comb begin
        prod_fix = neg_q ? -{dp_acc, dp_sh} : {dp_acc, dp_sh};
        if (div0_pend_q) begin
            lo_res = '1;
            hi_res = dp_sh;
        end else if (div_q) begin
            lo_res = neg_q  ? -dp_sh  : dp_sh;
            hi_res = rneg_q ? -dp_acc : dp_acc;
        end else begin
            lo_res = prod_fix[WIDTH-1:0];
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // Sign flags captured at start; HI/LO and div0 commit when DONE exits unflushed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            div_q       <= 1'b0;
            div0_pend_q <= 1'b0;
            div0_o      <= 1'b0;
            hi_o        <= '0;
            lo_o        <= '0;
        end else if (start) begin
            neg_q       <= (a_neg ^ b_neg) && !div_zero;
            rneg_q      <= a_neg && !div_zero;
            div_q       <= is_div;
            div0_pend_q <= div_zero;
            div0_o      <= 1'b0;
        end else if (done_o) begin
            hi_o   <= hi_res;
            lo_o   <= lo_res;
            div0_o <= div0_pend_q;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode sweep, mult/div results and
// timing, divide-by-zero, flush abort and reset abort.
module tb_alu_ctrl_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid, flush;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] src1, src2;
    logic [2:0]   aluctrl;
    logic         stall, done, div0;
    logic [W-1:0] hi, lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_ctrl_muldiv #(.WIDTH(W), .DIV_EN(1'b1)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .valid_i   (valid),
        .flush_i   (flush),
        .ALUOp_i   (aluop),
        .funct_i   (funct),
        .src1_i    (src1),
        .src2_i    (src2),
        .ALUCtrl_o (aluctrl),
        .stall_o   (stall),
        .done_o    (done),
        .div0_o    (div0),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] fn, input logic [2:0] exp);
        aluop = op;
        funct = fn;
        #1;
        chk($sformatf("decode_%b_%b", op, fn), aluctrl, exp);
    endtask

    // Issue one op in the current cycle, follow it to DONE, then score HI/LO/div0.
    task automatic run_op(input string tag, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_done_at, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic ediv0);
        exp_t e;
        int   stalls;
        int   done_at;
        e.hi = ehi;
        e.lo = elo;
        e.div0 = ediv0;
        sb.push_back(e);
        valid = 1'b1;
        aluop = 2'b10;
        funct = fn;
        src1  = a;
        src2  = b;
        #1;
        chk({tag, ":start_stall"}, stall, 1);
        stalls  = 1;
        done_at = -1;
        nxt();
        valid = 1'b0;
        funct = 6'b000000;
        #1;
        if (!ediv0) chk({tag, ":div0_cleared"}, div0, 0);
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                done_at = i;
                break;
            end
            if (stall) stalls++;
            nxt();
            #1;
        end
        chk({tag, ":done_cycle"}, done_at, exp_done_at);
        chk({tag, ":stall_cycles"}, stalls, exp_done_at);
        chk({tag, ":stall_in_done"}, stall, 0);
        nxt();
        #1;
        e = sb.pop_front();
        chk({tag, ":hi"}, hi, e.hi);
        chk({tag, ":lo"}, lo, e.lo);
        chk({tag, ":div0"}, div0, e.div0);
        chk({tag, ":done_pulse_end"}, done, 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        valid = 1'b0;
        flush = 1'b0;
        aluop = 2'b00;
        funct = 6'b000000;
        src1  = '0;
        src2  = '0;
        #2;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        dec(2'b10, 6'b100010, 3'b010);
        dec(2'b10, 6'b101010, 3'b111);
        dec(2'b10, 6'b010000, 3'b101);
        dec(2'b10, 6'b011000, 3'b000);
        chk("no_start_without_valid", stall, 0);
        dec(2'b10, 6'b010010, 3'b110);
        dec(2'b10, 6'b100000, 3'b001);
        dec(2'b10, 6'b111111, 3'b000);
        dec(2'b01, 6'b100100, 3'b011);
        dec(2'b11, 6'b100101, 3'b100);
        dec(2'b00, 6'b100010, 3'b001);
        dec(2'b00, 6'b011000, 3'b001);
        dec(2'b00, 6'b110011, 3'b001);

        run_op("mult_m3x7",   6'b011000, 32'hFFFFFFFD, 32'h7,        33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("div_m7d2",    6'b011010, 32'hFFFFFFF9, 32'h2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_big",    6'b011011, 32'hFFFFFFFF, 32'h10,       33, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
        run_op("div_min_m1",  6'b011010, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 1'b0);
        run_op("multu_max",   6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("divu_by0",    6'b011011, 32'h5,        32'h0,        1,  32'h00000005, 32'hFFFFFFFF, 1'b1);
        run_op("mult_2x2",    6'b011000, 32'h2,        32'h2,        33, 32'h00000000, 32'h00000004, 1'b0);
        run_op("mult_1x9",    6'b011000, 32'h1,        32'h9,        33, 32'h00000000, 32'h00000009, 1'b0);

        // flush in the start cycle suppresses the start
        valid = 1'b1;
        flush = 1'b1;
        aluop = 2'b10;
        funct = 6'b011000;
        src1  = 32'h3;
        src2  = 32'h3;
        #1;
        chk("flush_start_stall", stall, 0);
        nxt();
        valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_start_idle", stall, 0);

        // flush at iteration 10 of a multu
        valid = 1'b1;
        funct = 6'b011001;
        src1  = 32'd12345;
        src2  = 32'd678;
        #1;
        nxt();
        valid = 1'b0;
        repeat (9) nxt();
        flush = 1'b1;
        #1;
        chk("flush_iter10_stall", stall, 1);
        nxt();
        flush = 1'b0;
        #1;
        chk("flush_abort_stall", stall, 0);
        chk("flush_abort_done", done, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            nxt();
        end
        chk("flush_no_done", seen, 0);
        chk("flush_hi_kept", hi, 0);
        chk("flush_lo_kept", lo, 9);

        // reset at iteration 5 of a mult
        valid = 1'b1;
        funct = 6'b011000;
        src1  = 32'd6;
        src2  = 32'd7;
        #1;
        nxt();
        valid = 1'b0;
        repeat (4) nxt();
        rst_n = 1'b0;
        #1;
        chk("rstab_hi", hi, 0);
        chk("rstab_lo", lo, 0);
        chk("rstab_stall", stall, 0);
        chk("rstab_done", done, 0);
        chk("rstab_div0", div0, 0);
        #2;
        rst_n = 1'b1;
        nxt();
        run_op("mult_after_rst", 6'b011000, 32'hFFFFFFFB, 32'hFFFFFFFA, 33, 32'h00000000, 32'h0000001E, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
